// File: rtl/dmem_arb_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arb_pkg
// Brief    : Shared types and width defaults for the data-memory arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DMEM_DATA_W = 18;
   localparam int DMEM_ADDR_W = 18;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_VID  = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_VID  = 2'd2
   } rd_owner_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arbiter_if
// Brief    : CPU, video and RAM-side signal bundle of the data-memory arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface dmem_arbiter_if
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W = DMEM_DATA_W,
   parameter int ADDR_W = DMEM_ADDR_W
) ();

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_gnt;
   logic [DATA_W-1:0] vid_rdata;
   logic              vid_rvalid;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
      output cpu_stall, cpu_rdata, cpu_rvalid, vid_gnt, vid_rdata, vid_rvalid,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   // Requesters and RAM side
   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, mem_rdata,
      input  cpu_stall, cpu_rdata, cpu_rvalid, vid_gnt, vid_rdata, vid_rvalid,
             mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/dmem_arb_perf.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arb_perf
// Brief    : Saturating CPU-stall and video-beat event counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dmem_arb_perf (
   input  wire         clk,
   input  wire         rst,
   input  wire         i_stall,
   input  wire         i_vidBeat,
   output logic [31:0] o_stallCnt,
   output logic [31:0] o_vidBeats
);

   logic [31:0] r_stallCnt;
   logic [31:0] r_vidBeats;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stallCnt <= '0;
         r_vidBeats <= '0;
      end else begin
         if (i_stall && (r_stallCnt != '1)) r_stallCnt <= r_stallCnt + 32'd1;
         if (i_vidBeat && (r_vidBeats != '1)) r_vidBeats <= r_vidBeats + 32'd1;
      end
   end

   assign o_stallCnt = r_stallCnt;
   assign o_vidBeats = r_vidBeats;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : dmem_arbiter
// Brief    : CPU-priority arbiter for the single-port data RAM with starvation
//            guard and bounded video bursts. DMEM_ARB_PERF_EN adds perf counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int MAX_WAIT  = 4,
   parameter int BURST_LEN = 4
) (
   input  wire         clk,
   input  wire         rst,
`ifdef DMEM_ARB_PERF_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_vid_beats,
`endif
   dmem_arbiter_if.slave bus
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   localparam logic [WAIT_W-1:0] C_MAX_WAIT  = WAIT_W'(MAX_WAIT);
   localparam logic [BEAT_W-1:0] C_BURST_LEN = BEAT_W'(BURST_LEN);
   localparam logic [DATA_W-1:0] C_ZERO_DATA = '0;
   localparam logic [ADDR_W-1:0] C_ZERO_ADDR = '0;

   arb_state_t        r_state,   w_stateNxt;
   rd_owner_t         r_rdOwner, w_ownerNxt;
   logic [WAIT_W-1:0] r_waitCnt, w_waitNxt, w_waitEff;
   logic [BEAT_W-1:0] r_beatCnt, w_beatNxt;
   logic              w_cpuGnt, w_vidGnt, w_burstCont, w_cpuStall;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ARB_IDLE;
         r_rdOwner <= OWN_NONE;
         r_waitCnt <= '0;
         r_beatCnt <= '0;
      end else begin
         r_state   <= w_stateNxt;
         r_rdOwner <= w_ownerNxt;
         r_waitCnt <= w_waitNxt;
         r_beatCnt <= w_beatNxt;
      end
   end

   always_comb begin
      w_cpuGnt    = 1'b0;
      w_vidGnt    = 1'b0;
      w_stateNxt  = r_state;
      w_waitNxt   = r_waitCnt;
      w_beatNxt   = r_beatCnt;
      w_ownerNxt  = OWN_NONE;
      // A finished burst re-arbitrates as if the CPU had never waited.
      w_waitEff   = (r_state == ARB_VID) ? '0 : r_waitCnt;
      w_burstCont = (r_state == ARB_VID) && bus.vid_req && (r_beatCnt < C_BURST_LEN);

      if (!rst) begin
         if (w_burstCont) begin
            w_vidGnt  = 1'b1;
            w_beatNxt = r_beatCnt + BEAT_W'(1);
         end else if (bus.vid_req && (!bus.cpu_req || (w_waitEff == C_MAX_WAIT))) begin
            w_vidGnt   = 1'b1;
            w_stateNxt = ARB_VID;
            w_beatNxt  = BEAT_W'(1);
            w_waitNxt  = '0;
         end else if (bus.cpu_req) begin
            w_cpuGnt   = 1'b1;
            w_stateNxt = ARB_CPU;
            w_waitNxt  = (bus.vid_req && (w_waitEff != C_MAX_WAIT)) ?
                         w_waitEff + WAIT_W'(1) : w_waitEff;
         end else begin
            w_stateNxt = ARB_IDLE;
            w_waitNxt  = w_waitEff;
         end

         if (w_cpuGnt && !bus.cpu_we) w_ownerNxt = OWN_CPU;
         else if (w_vidGnt)           w_ownerNxt = OWN_VID;
      end
   end

   assign w_cpuStall     = !rst && bus.cpu_req && !w_cpuGnt;

   assign bus.cpu_stall  = w_cpuStall;
   assign bus.vid_gnt    = w_vidGnt;
   assign bus.mem_en     = w_cpuGnt | w_vidGnt;
   assign bus.mem_we     = w_cpuGnt & bus.cpu_we;
   assign bus.mem_addr   = rst ? C_ZERO_ADDR : (w_vidGnt ? bus.vid_addr : bus.cpu_addr);
   assign bus.mem_wdata  = rst ? C_ZERO_DATA : bus.cpu_wdata;

   // Both read ports share the RAM output; each is qualified by its own rvalid.
   assign bus.cpu_rvalid = !rst && (r_rdOwner == OWN_CPU);
   assign bus.vid_rvalid = !rst && (r_rdOwner == OWN_VID);
   assign bus.cpu_rdata  = rst ? C_ZERO_DATA : bus.mem_rdata;
   assign bus.vid_rdata  = rst ? C_ZERO_DATA : bus.mem_rdata;

`ifdef DMEM_ARB_PERF_EN
   dmem_arb_perf u_perf (
      .clk        (clk),
      .rst        (rst),
      .i_stall    (w_cpuStall),
      .i_vidBeat  (w_vidGnt),
      .o_stallCnt (perf_stall_cnt),
      .o_vidBeats (perf_vid_beats)
   );
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_dmem_arbiter
// Brief    : Directed self-checking bench for dmem_arbiter with a 1-cycle RAM.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic clk;
   logic rst;
   int   nTests = 0;
   int   nFail  = 0;

   dmem_arbiter_if bus ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perfStall, perfBeats;
`endif

   dmem_arbiter #(
      .DATA_W    (18),
      .ADDR_W    (18),
      .MAX_WAIT  (4),
      .BURST_LEN (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
`ifdef DMEM_ARB_PERF_EN
      .perf_stall_cnt (perfStall),
      .perf_vid_beats (perfBeats),
`endif
      .bus            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous single-port RAM, 1-cycle read latency
   logic [17:0] ramArr [0:255];
   initial begin
      for (int i = 0; i < 256; i++) ramArr[i] = 18'h100 + 18'(i);
      bus.mem_rdata = '0;
   end
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) ramArr[bus.mem_addr[7:0]] <= bus.mem_wdata;
         else            bus.mem_rdata <= ramArr[bus.mem_addr[7:0]];
      end
   end

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nTests++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cReq, input logic cWe, input logic [17:0] cAddr,
                        input logic [17:0] cData, input logic vReq, input logic [17:0] vAddr);
      bus.cpu_req   = cReq;
      bus.cpu_we    = cWe;
      bus.cpu_addr  = cAddr;
      bus.cpu_wdata = cData;
      bus.vid_req   = vReq;
      bus.vid_addr  = vAddr;
      #1;
   endtask

   logic [9:0] s3Vid, s3Stall, s3Cpu;
   logic       expV;
   int         tbStalls, tbBeats;

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      nextCycle();

      // Reset forces every grant and valid low even with both requesting
      drive(1, 1, 18'h10, 18'h1, 1, 18'h30);
      checkEq("rst_mem_en",     32'(bus.mem_en),     0);
      checkEq("rst_mem_we",     32'(bus.mem_we),     0);
      checkEq("rst_vid_gnt",    32'(bus.vid_gnt),    0);
      checkEq("rst_cpu_stall",  32'(bus.cpu_stall),  0);
      checkEq("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
      checkEq("rst_vid_rvalid", 32'(bus.vid_rvalid), 0);
      checkEq("rst_mem_addr",   32'(bus.mem_addr),   0);
      nextCycle();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      checkEq("idle_mem_en", 32'(bus.mem_en), 0);
      nextCycle();

      // Scenario 1: store then load, no video traffic
      drive(1, 1, 18'h00010, 18'h2ABCD, 0, 0);
      checkEq("s1_st_stall", 32'(bus.cpu_stall), 0);
      checkEq("s1_st_we",    32'(bus.mem_we),    1);
      checkEq("s1_st_addr",  32'(bus.mem_addr),  32'h10);
      nextCycle();
      drive(1, 0, 18'h00010, 0, 0, 0);
      checkEq("s1_ld_stall",     32'(bus.cpu_stall),  0);
      checkEq("s1_ld_we",        32'(bus.mem_we),     0);
      checkEq("s1_st_no_rvalid", 32'(bus.cpu_rvalid), 0);
      nextCycle();
      drive(0, 0, 0, 0, 0, 0);
      checkEq("s1_rvalid", 32'(bus.cpu_rvalid), 1);
      checkEq("s1_rdata",  32'(bus.cpu_rdata),  32'h2ABCD);
      checkEq("s1_vrv",    32'(bus.vid_rvalid), 0);
      nextCycle();

      // Scenario 2: CPU holds, video starves for MAX_WAIT then bursts BURST_LEN
      for (int k = 0; k < 9; k++) begin
         drive(1, 0, 18'h00010, 0, 1, 18'h00030);
         expV = (k >= 4 && k <= 7);
         checkEq($sformatf("s2_vgnt_%0d", k),  32'(bus.vid_gnt),   32'(expV));
         checkEq($sformatf("s2_stall_%0d", k), 32'(bus.cpu_stall), 32'(expV));
         if (k == 4) checkEq("s2_vaddr", 32'(bus.mem_addr), 32'h30);
         if (k == 5) begin
            checkEq("s2_vrv",   32'(bus.vid_rvalid), 1);
            checkEq("s2_vdata", 32'(bus.vid_rdata),  32'h130);
            checkEq("s2_crv",   32'(bus.cpu_rvalid), 0);
         end
         nextCycle();
      end
      drive(0, 0, 0, 0, 0, 0);
      nextCycle();

      // Scenario 3: video-only burst, CPU arrives mid-burst
      s3Vid   = 10'b1111001111;
      s3Stall = 10'b0000001100;
      s3Cpu   = 10'b0000111100;
      for (int k = 0; k < 10; k++) begin
         drive(s3Cpu[k], 0, 18'h00010, 0, 1, 18'h00040 + 18'(k));
         checkEq($sformatf("s3_vgnt_%0d", k),  32'(bus.vid_gnt),   32'(s3Vid[k]));
         checkEq($sformatf("s3_stall_%0d", k), 32'(bus.cpu_stall), 32'(s3Stall[k]));
         checkEq($sformatf("s3_men_%0d", k),   32'(bus.mem_en),    32'(s3Vid[k] | s3Cpu[k]));
         nextCycle();
      end
      drive(0, 0, 0, 0, 0, 0);
      nextCycle();

      // Scenario 4: same-cycle store and video read of one address
      drive(1, 1, 18'h00020, 18'h15555, 1, 18'h00020);
      checkEq("s4_stall", 32'(bus.cpu_stall), 0);
      checkEq("s4_vgnt0", 32'(bus.vid_gnt),   0);
      checkEq("s4_we",    32'(bus.mem_we),    1);
      nextCycle();
      drive(0, 0, 0, 0, 1, 18'h00020);
      checkEq("s4_vgnt1", 32'(bus.vid_gnt),  1);
      checkEq("s4_vaddr", 32'(bus.mem_addr), 32'h20);
      nextCycle();
      drive(0, 0, 0, 0, 0, 0);
      checkEq("s4_vrv",   32'(bus.vid_rvalid), 1);
      checkEq("s4_vdata", 32'(bus.vid_rdata),  32'h15555);
      nextCycle();

      // Scenario 5: reset right after a video grant drops the read
      drive(0, 0, 0, 0, 1, 18'h00030);
      checkEq("s5_vgnt", 32'(bus.vid_gnt), 1);
      nextCycle();
      rst = 1'b1;
      drive(1, 0, 18'h00010, 0, 1, 18'h00031);
      checkEq("s5_rst_vrv",   32'(bus.vid_rvalid), 0);
      checkEq("s5_rst_men",   32'(bus.mem_en),     0);
      checkEq("s5_rst_vgnt",  32'(bus.vid_gnt),    0);
      checkEq("s5_rst_stall", 32'(bus.cpu_stall),  0);
      nextCycle();
      rst = 1'b0;
      drive(1, 0, 18'h00010, 0, 0, 0);
      checkEq("s5_cpu_first", 32'(bus.cpu_stall),  0);
      checkEq("s5_cpu_men",   32'(bus.mem_en),     1);
      checkEq("s5_no_vrv",    32'(bus.vid_rvalid), 0);
      checkEq("s5_beat",      32'(dut.r_beatCnt),  0);
      checkEq("s5_wait",      32'(dut.r_waitCnt),  0);
      nextCycle();
      drive(0, 0, 0, 0, 0, 0);
      checkEq("s5_crv",   32'(bus.cpu_rvalid), 1);
      checkEq("s5_cdata", 32'(bus.cpu_rdata),  32'h2ABCD);
      nextCycle();

      // Scenario 6: 20 cycles of contention from a clean reset
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      tbStalls = 0;
      tbBeats  = 0;
      for (int k = 0; k < 20; k++) begin
         drive(1, 0, 18'h00010, 0, 1, 18'h00050);
         expV = ((k % 8) >= 4);
         checkEq($sformatf("s6_vgnt_%0d", k),  32'(bus.vid_gnt),   32'(expV));
         checkEq($sformatf("s6_stall_%0d", k), 32'(bus.cpu_stall), 32'(expV));
         if (expV) begin
            tbStalls++;
            tbBeats++;
         end
         nextCycle();
      end
      drive(0, 0, 0, 0, 0, 0);
`ifdef DMEM_ARB_PERF_EN
      checkEq("s6_perf_stall", perfStall, 32'(tbStalls));
      checkEq("s6_perf_beats", perfBeats, 32'(tbBeats));
      checkEq("s6_perf_stall_abs", perfStall, 32'd8);
`endif
      nextCycle();

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
`default_nettype wire
